// File: rtl/mul_pkg.sv
// Shared definitions for the iterative RV32M multiplier: op codes, FSM states
// and helpers used by both the sequencer and its datapath.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_HSS = 2'b01,
    MUL_HSU = 2'b10,
    MUL_HUU = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_e;

  function automatic int cnt_width(input int xlen);
    return $clog2(xlen);
  endfunction

  // MULH and MULHSU treat rs1 as signed; only MULH treats rs2 as signed.
  function automatic logic op_a_signed(input mul_op_e op);
    return (op == MUL_HSS) || (op == MUL_HSU);
  endfunction

  function automatic logic op_b_signed(input mul_op_e op);
    return (op == MUL_HSS);
  endfunction

endpackage

// File: rtl/mul_datapath.sv
// Operand, accumulator and result registers of the shift-add multiplier,
// sequenced by load/step/finish strobes from mul_seq.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            finish,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  mul_op_e           op_in;
  mul_op_e           op_q;
  logic              sa_in, sb_in;
  logic              sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN-1:0]   mcand, mplier;
  logic [2*XLEN-1:0] acc, acc_next, prod;
  logic [XLEN:0]     sum;
  logic [XLEN-1:0]   res_next;
  logic              unused_acc_lsb;

  always_comb begin
    op_in = mul_op_e'(op);
    sa_in = a[XLEN-1] & op_a_signed(op_in);
    sb_in = b[XLEN-1] & op_b_signed(op_in);
    a_mag = sa_in ? -a : a;
    b_mag = sb_in ? -b : b;
  end

  // The final step and the sign fixup happen in the same edge, so the result
  // is built from the post-step accumulator rather than the registered one.
  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_next = {sum, acc[XLEN-1:1]};
    prod     = (sa ^ sb) ? -acc_next : acc_next;
    res_next = (op_q == MUL_LO) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  assign unused_acc_lsb = acc[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= MUL_LO;
      sa     <= 1'b0;
      sb     <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      if (load) begin
        op_q   <= op_in;
        sa     <= sa_in;
        sb     <= sb_in;
        mcand  <= a_mag;
        mplier <= b_mag;
        acc    <= '0;
      end else if (step) begin
        acc    <= acc_next;
        mplier <= mplier >> 1;
      end
      if (finish) begin
        result <= res_next;
      end
    end
  end

endmodule

// File: rtl/mul_seq.sv
// Radix-2 shift-add multiply sequencer: accepts one RV32M multiply, iterates
// one multiplier bit per cycle while busy, then pulses done with the result.
module mul_seq
  import mul_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int            CW       = cnt_width(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  mul_state_e    state, state_next;
  logic [CW-1:0] count;
  logic          load, step, finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_RUN);
      done  <= finish;
      if (load) begin
        count <= '0;
      end else if (step) begin
        count <= count + CW'(1);
      end
    end
  end

  // Flush wins over everything; start is only honoured in IDLE and DONE.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !flush) begin
          state_next = ST_RUN;
          load       = 1'b1;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else begin
          step = 1'b1;
          if (count == CNT_LAST) begin
            state_next = ST_DONE;
            finish     = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (start && !flush) begin
          state_next = ST_RUN;
          load       = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  mul_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .step  (step),
    .finish(finish),
    .op    (op),
    .a     (a),
    .b     (b),
    .result(result)
  );

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases plus random ops
// compared against a plain-arithmetic reference of the RV32M multiplies.
module tb_mul_seq;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a, b;
  logic            flush;
  logic            busy, done;
  logic [XLEN-1:0] result;

  int checks = 0;
  int errors = 0;

  mul_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  // Reference: extend each operand to 2*XLEN per its signedness and multiply.
  function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] o, input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y);
    logic [2*XLEN-1:0] ex, ey, p;
    ex = (o == 2'b01 || o == 2'b10) ? {{XLEN{x[XLEN-1]}}, x} : {{XLEN{1'b0}}, x};
    ey = (o == 2'b01) ? {{XLEN{y[XLEN-1]}}, y} : {{XLEN{1'b0}}, y};
    p  = ex * ey;
    return (o == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] o, input logic [XLEN-1:0] x,
                               input logic [XLEN-1:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Entered in cycle 1 after accept; returns the cycle done was seen in.
  task automatic waitDone(output int cyc, output int busy_cycles);
    cyc = 1;
    busy_cycles = 0;
    while (done !== 1'b1 && cyc <= XLEN + 8) begin
      if (busy === 1'b1) busy_cycles++;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  initial begin
    int            cyc, bc, any_done;
    logic [XLEN-1:0] held, ra, rb;
    logic [1:0]      ro;

    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] MUL 3 x -5 latency and busy window");
    applyStimulus(2'b00, 32'd3, 32'hFFFF_FFFB);
    waitDone(cyc, bc);
    checkOutput("mul_done_cycle", 32'(cyc), 32'(XLEN + 1));
    checkOutput("mul_busy_cycles", 32'(bc), 32'(XLEN));
    checkOutput("mul_busy_at_done", 32'(busy), 32'd0);
    checkOutput("mul_result", result, 32'hFFFF_FFF1);
    @(posedge clk);
    #1;
    checkOutput("done_pulse_width", 32'(done), 32'd0);
    checkOutput("result_held", result, 32'hFFFF_FFF1);

    $display("[TB] high-half corner cases");
    applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000);
    waitDone(cyc, bc);
    checkOutput("mulh_minneg", result, 32'h4000_0000);
    applyStimulus(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(cyc, bc);
    checkOutput("mulhu_allones", result, 32'hFFFF_FFFE);
    applyStimulus(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone(cyc, bc);
    checkOutput("mulhsu_neg1", result, 32'hFFFF_FFFF);
    applyStimulus(2'b11, 32'd0, $urandom);
    waitDone(cyc, bc);
    checkOutput("mulhu_zero", result, 32'd0);

    $display("[TB] back-to-back with start held through RUN");
    start = 1'b1;
    op    = 2'b00;
    a     = 32'h1234_5678;
    b     = 32'd3;
    @(posedge clk);
    #1;
    a = 32'd7;
    b = 32'd6;
    waitDone(cyc, bc);
    checkOutput("b2b_first_cycle", 32'(cyc), 32'(XLEN + 1));
    checkOutput("b2b_first_result", result, 32'h369D_0368);
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(cyc, bc);
    checkOutput("b2b_second_cycle", 32'(cyc + XLEN + 1), 32'(2 * XLEN + 2));
    checkOutput("b2b_second_result", result, 32'd42);

    $display("[TB] flush mid-RUN and flush with start in IDLE");
    @(posedge clk);
    #1;
    held = result;
    applyStimulus(2'b00, 32'd9, 32'd9);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    checkOutput("busy_before_flush", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flush_busy_drop", 32'(busy), 32'd0);
    any_done = 0;
    repeat (XLEN + 4) begin
      if (done === 1'b1 || busy === 1'b1) any_done++;
      @(posedge clk);
      #1;
    end
    checkOutput("flush_no_activity", 32'(any_done), 32'd0);
    checkOutput("flush_result_kept", result, held);
    start = 1'b1;
    flush = 1'b1;
    op    = 2'b00;
    a     = 32'd5;
    b     = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    any_done = 0;
    repeat (XLEN + 4) begin
      if (done === 1'b1 || busy === 1'b1) any_done++;
      @(posedge clk);
      #1;
    end
    checkOutput("flush_start_stays_idle", 32'(any_done), 32'd0);

    $display("[TB] asynchronous reset mid-RUN");
    applyStimulus(2'b11, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_done", 32'(done), 32'd0);
    checkOutput("arst_result", result, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(2'b00, 32'd2, 32'd2);
    waitDone(cyc, bc);
    checkOutput("post_reset_cycle", 32'(cyc), 32'(XLEN + 1));
    checkOutput("post_reset_result", result, 32'd4);

    $display("[TB] random operations against reference");
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'h8000_0000;
        1: rb = 32'd1;
        default: rb = $urandom;
      endcase
      applyStimulus(ro, ra, rb);
      waitDone(cyc, bc);
      checkOutput("rand_cycle", 32'(cyc), 32'(XLEN + 1));
      checkOutput("rand_result", result, ref_mul(ro, ra, rb));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
